demux_router: RTL and testbench

DEMUX_ROUTER -- requirements
Module: demux_router

---
 rtl/demux_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/demux_router.sv | 105 ++++++++++
 tb/tb_demux_router.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared widths, select encoding and data type for demux_router.
// Revision : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with extra-bit pointers; head byte reads 0 when empty.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Same index with differing wrap bits means the writer is a full lap ahead.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux_router.sv
// ============================================================================
// Module   : demux_router
// Brief    : Routes input bytes into one of two per-port FIFOs by in_sel.
//            Define DEMUX_CNT_EN to add per-port delivered-byte counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_router
    import demux_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
`ifdef DEMUX_CNT_EN
    input  logic              b_ready,
    output logic [CNT_W-1:0]  a_count,
    output logic [CNT_W-1:0]  b_count
`else
    input  logic              b_ready
`endif
);

    logic a_full, a_empty, b_full, b_empty;
    logic push_a, push_b, pop_a, pop_b;
    logic accept;

    // Readiness looks only at fullness so it never depends on a same-cycle pop.
    always_comb begin
        in_ready = (in_sel == SEL_A) ? !a_full : !b_full;
        accept   = in_valid && in_ready;
        push_a   = accept && (in_sel == SEL_A);
        push_b   = accept && (in_sel == SEL_B);
        a_valid  = !a_empty;
        b_valid  = !b_empty;
        pop_a    = a_valid && a_ready;
        pop_b    = b_valid && b_ready;
    end

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .pop       (pop_a),
        .pop_data  (a_data),
        .full      (a_full),
        .empty     (a_empty)
    );

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .pop       (pop_b),
        .pop_data  (b_data),
        .full      (b_full),
        .empty     (b_empty)
    );

`ifdef DEMUX_CNT_EN
    cnt_t a_count_q, a_count_d;
    cnt_t b_count_q, b_count_d;

    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (pop_a) a_count_d = a_count_q + cnt_t'(1);
        if (pop_b) b_count_d = b_count_q + cnt_t'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_count = a_count_q;
    assign b_count = b_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_router.sv
// ============================================================================
// Module   : tb_demux_router
// Brief    : Directed self-checking bench for demux_router (DEPTH=4).
//            Counter wrap checks are built in when DEMUX_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_demux_router;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
`ifdef DEMUX_CNT_EN
    logic [15:0] a_count;
    logic [15:0] b_count;
`endif

    int n_tests;
    int n_fail;

    demux_router #(.DEPTH(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
`ifdef DEMUX_CNT_EN
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
`else
        .b_ready  (b_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the falling edge.
    task automatic half_step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_sel   = 1'b1;
        in_valid = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;

        // Reset state
        half_step();
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_a_data", 32'(a_data), 32'h00);
        check("rst_b_data", 32'(b_data), 32'h00);
`ifdef DEMUX_CNT_EN
        check("rst_a_count", 32'(a_count), 32'd0);
        check("rst_b_count", 32'(b_count), 32'd0);
`endif
        rst_n = 1'b1;

        // Basic routing, one-cycle latency
        half_step();
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h11;
        half_step();
        check("s1_a_valid", 32'(a_valid), 32'd1);
        check("s1_a_data", 32'(a_data), 32'h11);
        check("s1_b_valid_idle", 32'(b_valid), 32'd0);
        in_sel = 1'b0; in_data = 8'h22;
        half_step();
        check("s1_a_drained", 32'(a_valid), 32'd0);
        check("s1_b_valid", 32'(b_valid), 32'd1);
        check("s1_b_data", 32'(b_data), 32'h22);
        in_valid = 1'b0;
        half_step();
        check("s1_b_drained", 32'(b_valid), 32'd0);

        // Fill A; B still accepts
        a_ready = 1'b0; b_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            half_step();
            in_valid = 1'b1; in_sel = 1'b1; in_data = 8'(i);
            #1;
            check("s2_in_ready_fill", 32'(in_ready), 32'd1);
        end
        half_step();
        in_valid = 1'b0; in_sel = 1'b1;
        #1;
        check("s2_in_ready_full", 32'(in_ready), 32'd0);
        check("s2_a_head", 32'(a_data), 32'h01);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55;
        #1;
        check("s2_in_ready_b", 32'(in_ready), 32'd1);
        half_step();
        in_valid = 1'b0;
        check("s2_b_valid", 32'(b_valid), 32'd1);
        check("s2_b_data", 32'(b_data), 32'h55);
        check("s2_a_still_head", 32'(a_data), 32'h01);
        b_ready = 1'b1;
        half_step();
        check("s2_b_drained", 32'(b_valid), 32'd0);

        // Drain A in order
        in_sel  = 1'b1;
        a_ready = 1'b1;
        #1;
        check("s3_in_ready_before_pop", 32'(in_ready), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            half_step();
            check("s3_a_valid", 32'(a_valid), 32'd1);
            check("s3_a_data", 32'(a_data), 32'(k));
            if (k == 2) check("s3_in_ready_after_pop", 32'(in_ready), 32'd1);
        end
        half_step();
        check("s3_a_empty", 32'(a_valid), 32'd0);

        // Streaming push+pop on A across pointer wrap
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                check("s4_a_valid", 32'(a_valid), 32'd1);
                check("s4_a_data", 32'(a_data), 32'(8'h80 + 8'(i - 1)));
            end
            in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h80 + 8'(i);
            half_step();
        end
        in_valid = 1'b0;
        check("s4_last_head", 32'(a_data), 32'h8A);
        half_step();
        check("s4_a_empty", 32'(a_valid), 32'd0);

        // Asynchronous reset discards buffered bytes
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h31;
        half_step();
        in_data = 8'h32;
        half_step();
        in_sel = 1'b0; in_data = 8'h33;
        half_step();
        in_valid = 1'b0;
        check("s5_a_buffered", 32'(a_valid), 32'd1);
        check("s5_b_buffered", 32'(b_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("s5_a_valid_async", 32'(a_valid), 32'd0);
        check("s5_b_valid_async", 32'(b_valid), 32'd0);
        check("s5_a_data_rst", 32'(a_data), 32'h00);
        check("s5_in_ready_rst", 32'(in_ready), 32'd1);
        half_step();
        rst_n = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1;
        half_step();
        check("s5_no_stale_a", 32'(a_valid), 32'd0);
        check("s5_no_stale_b", 32'(b_valid), 32'd0);
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h44;
        half_step();
        in_valid = 1'b0;
        check("s5_fresh_a", 32'(a_data), 32'h44);
        half_step();
        check("s5_fresh_drained", 32'(a_valid), 32'd0);

`ifdef DEMUX_CNT_EN
        // Counter wrap: 65534 pops reach 0xFFFE, two more wrap to 0
        rst_n = 1'b0;
        half_step();
        rst_n = 1'b1;
        check("s6_a_count_zero", 32'(a_count), 32'd0);
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'hC3; a_ready = 1'b1;
        repeat (65535) @(negedge clk);
        #1;
        check("s6_a_count_fffe", 32'(a_count), 32'hFFFE);
        repeat (2) @(negedge clk);
        #1;
        check("s6_a_count_wrap", 32'(a_count), 32'h0000);
        check("s6_b_count_idle", 32'(b_count), 32'h0000);
        in_valid = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
